fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset, word-aligned.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port redirect  input  1  pulse: restart fetch at redirect_pc.
REQ-005 SHALL have port redirect_pc  input  32  new fetch byte address; bits [1:0] ignored.
REQ-006 SHALL have port mem_addr  output  30  word address to instruction RAM.
REQ-007 SHALL have port mem_re  output  1  RAM read enable.
REQ-008 SHALL have port mem_rdata  input  32  RAM read data, valid the cycle after mem_re.
REQ-009 SHALL have port out_valid  output  1  instruction available to decode.
REQ-010 SHALL have port out_ready  input  1  decode accepts instruction this cycle.
REQ-011 SHALL have port out_instr  output  32  instruction word.
REQ-012 SHALL have port out_pc  output  32  byte address of out_instr, bits [1:0] = 0.

Function
REQ-013 SHALL hold a fetch PC (pc_f); mem_addr SHALL equal pc_f[31:2], or redirect_pc[31:2] in a redirect cycle.
REQ-014 SHALL keep a 2-entry FIFO of {pc, instr}; out_valid = FIFO non-empty; out_instr/out_pc = head entry; no bypass.
REQ-015 SHALL track inflight (1 bit): set in any cycle mem_re=1, cleared otherwise.
REQ-016 SHALL assert mem_re when count + inflight - pop < 2, where pop = out_valid & out_ready; on issue pc_f advances by 4.
REQ-017 SHALL push {issued pc, mem_rdata} into the FIFO in the cycle after an issue, unless killed (REQ-019).
REQ-018 SHALL support simultaneous push and pop with count unchanged; count never exceeds 2.
REQ-019 On redirect=1: FIFO flushed, response of any read issued the previous cycle discarded, mem_re=1 at redirect_pc[31:2], pc_f <= {redirect_pc[31:2],2'b00} + 4.
REQ-020 out_valid SHALL be 0 in the cycle after redirect; the first post-redirect instruction SHALL be out_valid two cycles after redirect.
REQ-021 Latency: issue in cycle N -> out_valid with that instruction in cycle N+2.
REQ-022 Throughput: with out_ready held high, SHALL deliver one instruction per cycle continuously.
REQ-023 out_instr/out_pc SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 pc_f SHALL wrap from 32'hFFFF_FFFC to 0 without special handling.
REQ-025 redirect SHALL take priority over pop; a pop in a redirect cycle is discarded.

Reset
REQ-026 While reset=1: pc_f=RESET_PC, FIFO empty, inflight=0, mem_re=0, out_valid=0, out_instr=0, out_pc=0.
REQ-027 First cycle with reset=0 SHALL issue mem_re=1 at RESET_PC[31:2]; reset mid-operation SHALL discard the in-flight response.
REQ-028 redirect asserted during reset SHALL be ignored.

Structure
REQ-029 RESET_PC default and the 32-bit instruction/address widths SHALL be constants in a shared package frost_pkg.
REQ-030 The 2-entry FIFO SHALL be a sub-module fetch_fifo (push, pop, flush, count, head outputs).
REQ-031 SHALL be synthesizable with no latches; single clock domain.

Verification
REQ-032 RAM preloaded 0x00200093, 0x00300113, 0x001101b3, 0x00100073; reset released, out_ready=1 -> out_valid from cycle 2, pc 0,4,8,C in consecutive cycles with those words.
REQ-033 out_ready=0 from cycle 2 for 5 cycles -> exactly 2 reads issued, out_pc=0 held stable, count=2; ready restored -> pcs 0,4,8 in order, none lost or duplicated.
REQ-034 redirect=1, redirect_pc=0x40 while FIFO holds pc 4,8 -> next out_valid instruction has out_pc=0x40, pc 4/8/C never delivered.
REQ-035 redirect_pc=0x43 -> mem_addr=0x10, out_pc=0x40.
REQ-036 reset asserted mid-stream with FIFO full -> next cycle out_valid=0, mem_re=0; after release fetch restarts at RESET_PC.
REQ-037 Random out_ready at 50 percent over 1000 cycles -> out_pc strictly +4 sequence, count never above 2.

Source files
------------

// File: rtl/frost_pkg.sv
// Shared widths, reset address and the fetch-queue entry type for the frost front end.
package frost_pkg;

  localparam int XLEN       = 32;
  localparam int ILEN       = 32;
  localparam int WADDR_W    = XLEN - 2;
  localparam int FIFO_DEPTH = 2;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One decoded-side slot: the instruction word and the byte address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Clears the byte offset so every fetch address lands on a word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry queue of fetched {pc, instr} pairs; head is registered storage, no bypass.
module fetch_fifo
  import frost_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t slots [FIFO_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         push_ok;
  logic         pop_ok;

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'(FIFO_DEPTH)) || pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the two slots are reset (not just the pointers) so the head
      // reads as zero while reset is held; a deep memory would not do this.
      slots[0] <= '0;
      slots[1] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        slots[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = slots[rd_ptr];

endmodule

// File: rtl/fetch.sv
// Instruction fetch: issues word reads to a 1-cycle RAM and queues responses for decode.
module fetch
  import frost_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic [WADDR_W-1:0] mem_addr,
  output logic               mem_re,
  input  logic [ILEN-1:0]    mem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ILEN-1:0]    out_instr,
  output logic [XLEN-1:0]    out_pc
);

  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] pc_issued;
  logic [XLEN-1:0] redirect_base;
  logic            inflight;
  logic            take_redirect;
  logic            pop;
  logic            push;
  logic [1:0]      fifo_count;
  logic [2:0]      credit_used;
  fetch_entry_t    head;
  fetch_entry_t    push_data;

  assign take_redirect = redirect & ~reset;
  assign redirect_base = align_pc(redirect_pc);

  // A redirect flushes the queue, so a handshake in that cycle is dropped.
  assign pop  = out_valid & out_ready & ~take_redirect;
  assign push = inflight & ~take_redirect;

  assign push_data = '{pc: pc_issued, instr: mem_rdata};

  // Slots already spoken for are queued entries plus the read still in flight;
  // a pop this cycle frees one, so the compare is done without subtraction.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    mem_re      = 1'b0;
    mem_addr    = pc_f[XLEN-1:2];
    credit_used = {1'b0, fifo_count} + {2'b00, inflight};
    if (reset) begin
      mem_re = 1'b0;
    end else if (take_redirect) begin
      mem_re   = 1'b1;
      mem_addr = redirect_base[XLEN-1:2];
    end else begin
      mem_re = credit_used < (3'd2 + {2'b00, pop});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values of the others.
      pc_f      <= align_pc(RESET_PC);
      pc_issued <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= mem_re;
      if (mem_re) begin
        pc_issued <= {mem_addr, 2'b00};
      end
      if (take_redirect) begin
        pc_f <= redirect_base + 32'd4;
      end else if (mem_re) begin
        pc_f <= pc_f + 32'd4;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (take_redirect),
    .push_data (push_data),
    .count     (fifo_count),
    .head      (head)
  );

  assign out_valid = (fifo_count != 2'd0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: 1-cycle RAM model plus an expected-stream scoreboard.
module tb_fetch;
  import frost_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [29:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int checks = 0;
  int errors = 0;
  fetch_entry_t exp_q[$];

  always #5 clk = ~clk;

  fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
  );

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    case (a)
      30'd0:   return 32'h0020_0093;
      30'd1:   return 32'h0030_0113;
      30'd2:   return 32'h0011_01b3;
      30'd3:   return 32'h0010_0073;
      default: return {a[27:0], 4'h3} ^ 32'h5A5A_0000;
    endcase
  endfunction

  // RAM: data valid the cycle after the read; poison otherwise.
  always @(posedge clk) mem_rdata <= mem_re ? mem_word(mem_addr) : 32'hDEAD_BEEF;

  task automatic push_expected(input logic [31:0] start, input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = start + 32'(4 * i);
      exp_q.push_back('{pc: pc, instr: mem_word(pc[31:2])});
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    redirect = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0100; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      checks++;
      if (mem_re !== 1'b0 || out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0) begin
        errors++;
        $display("FAIL reset_state: mem_re=%b out_valid=%b out_instr=%h out_pc=%h, expected 0 0 0 0",
                 mem_re, out_valid, out_instr, out_pc);
      end
    end
    redirect = 1'b0;
  endtask

  task automatic test_startup();
    fetch_entry_t e;
    reset = 1'b0; out_ready = 1'b1;
    exp_q.delete(); push_expected(32'h0, 4);
    #1;
    checks++;
    if (mem_re !== 1'b1 || mem_addr !== 30'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL startup_issue: mem_re=%b mem_addr=%h out_valid=%b, expected 1 0 0", mem_re, mem_addr, out_valid);
    end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); #1;
      if (c == 1) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL startup_c1_valid: out_valid=%b expected 0", out_valid);
        end
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== e.pc || out_instr !== e.instr) begin
          errors++;
          $display("FAIL startup_c%0d: valid=%b pc=%h instr=%h, expected 1 %h %h", c, out_valid, out_pc, out_instr, e.pc, e.instr);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    fetch_entry_t e;
    int issues;
    apply_reset();
    out_ready = 1'b0; reset = 1'b0; issues = 0;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (mem_re) issues++;
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0020_0093) begin
          errors++;
          $display("FAIL stall_hold_c%0d: valid=%b pc=%h instr=%h, expected 1 0 00200093", c, out_valid, out_pc, out_instr);
        end
      end
    end
    checks++;
    if (issues != 2) begin
      errors++; $display("FAIL stall_reads: issued=%0d expected 2", issues);
    end
    checks++;
    if (dut.fifo_count !== 2'd2) begin
      errors++; $display("FAIL stall_count: count=%0d expected 2", dut.fifo_count);
    end
    exp_q.delete(); push_expected(32'h0, 3);
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk); out_ready = 1'b1; #1;
      if (out_valid) begin
        e = exp_q.pop_front();
        checks++;
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          errors++; $display("FAIL stall_drain: pc=%h instr=%h, expected %h %h", out_pc, out_instr, e.pc, e.instr);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL stall_drain_timeout: %0d instructions missing", exp_q.size());
    end
  endtask

  task automatic test_redirect();
    fetch_entry_t e;
    apply_reset();
    out_ready = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clk);
    out_ready = 1'b1; #1;
    checks++;
    if (dut.fifo_count !== 2'd2 || out_pc !== 32'h0) begin
      errors++; $display("FAIL redir_setup_c3: count=%0d pc=%h, expected 2 0", dut.fifo_count, out_pc);
    end
    @(negedge clk); out_ready = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (dut.fifo_count !== 2'd2 || out_pc !== 32'h4) begin
      errors++; $display("FAIL redir_setup_c5: count=%0d pc=%h, expected 2 4", dut.fifo_count, out_pc);
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0043; out_ready = 1'b1;
    exp_q.delete(); push_expected(32'h40, 3);
    #1;
    checks++;
    if (mem_re !== 1'b1 || mem_addr !== 30'h10) begin
      errors++; $display("FAIL redir_issue: mem_re=%b mem_addr=%h, expected 1 10", mem_re, mem_addr);
    end
    @(negedge clk); redirect = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL redir_bubble: out_valid=%b expected 0", out_valid);
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk); #1;
      if (c == 0 || out_valid) begin
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== e.pc || out_instr !== e.instr) begin
          errors++; $display("FAIL redir_stream: valid=%b pc=%h instr=%h, expected 1 %h %h", out_valid, out_pc, out_instr, e.pc, e.instr);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL redir_timeout: %0d instructions missing", exp_q.size());
    end
  endtask

  // Redirect out of a full-rate stream onto the top of memory; checks wrap and throughput.
  task automatic test_back_to_back();
    fetch_entry_t e;
    @(negedge clk);
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    exp_q.delete(); push_expected(32'hFFFF_FFF8, 4);
    #1;
    checks++;
    if (mem_re !== 1'b1 || mem_addr !== 30'h3FFF_FFFE) begin
      errors++; $display("FAIL wrap_issue: mem_re=%b mem_addr=%h, expected 1 3ffffffe", mem_re, mem_addr);
    end
    @(negedge clk); redirect = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_bubble: out_valid=%b expected 0", out_valid);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== e.pc || out_instr !== e.instr) begin
        errors++; $display("FAIL wrap_stream_%0d: valid=%b pc=%h instr=%h, expected 1 %h %h", c, out_valid, out_pc, out_instr, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_reset_mid();
    fetch_entry_t e;
    apply_reset();
    out_ready = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (dut.fifo_count !== 2'd2) begin
      errors++; $display("FAIL midreset_full: count=%0d expected 2", dut.fifo_count);
    end
    reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || mem_re !== 1'b0) begin
      errors++; $display("FAIL midreset_state: out_valid=%b mem_re=%b, expected 0 0", out_valid, mem_re);
    end
    reset = 1'b0; out_ready = 1'b1;
    exp_q.delete(); push_expected(32'h0, 2);
    #1;
    checks++;
    if (mem_re !== 1'b1 || mem_addr !== 30'h0) begin
      errors++; $display("FAIL midreset_restart: mem_re=%b mem_addr=%h, expected 1 0", mem_re, mem_addr);
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk); #1;
      if (out_valid) begin
        e = exp_q.pop_front();
        checks++;
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          errors++; $display("FAIL midreset_stream: pc=%h instr=%h, expected %h %h", out_pc, out_instr, e.pc, e.instr);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL midreset_timeout: %0d instructions missing", exp_q.size());
    end
  endtask

  task automatic test_random_ready();
    fetch_entry_t e;
    logic        hold;
    logic [31:0] held_pc, held_instr;
    apply_reset();
    reset = 1'b0; hold = 1'b0; held_pc = '0; held_instr = '0;
    exp_q.delete(); push_expected(32'h0, 1000);
    for (int c = 0; c < 1000; c++) begin
      if (c > 0) @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (dut.fifo_count > 2'd2) begin
        errors++; $display("FAIL rand_count_c%0d: count=%0d expected <=2", c, dut.fifo_count);
      end
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== held_pc || out_instr !== held_instr) begin
          errors++; $display("FAIL rand_stable_c%0d: valid=%b pc=%h instr=%h, expected 1 %h %h", c, out_valid, out_pc, out_instr, held_pc, held_instr);
        end
      end
      hold = out_valid & ~out_ready;
      held_pc = out_pc; held_instr = out_instr;
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          errors++; $display("FAIL rand_order_c%0d: pc=%h instr=%h, expected %h %h", c, out_pc, out_instr, e.pc, e.instr);
        end
      end
    end
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_startup();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_reset_mid();
    test_random_ready();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
